// File: rtl/data_transmitter_fifo_pkg.sv
// Shared helpers for the data transmitter: clog2, default credit rule
// and the never-happens check macro used for credit overflow/underflow.
`ifndef DATA_TRANSMITTER_FIFO_PKG_SV
`define DATA_TRANSMITTER_FIFO_PKG_SV

`define DTF_NEVER(lbl, cond, msg) \
  lbl: assert property ( \
    @(posedge clk) disable iff (!reset) !(cond)) \
    else begin $error(msg); $finish; end

package data_transmitter_fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Receiver buffer must hold every result still in the FU pipe
  // plus the one being handed over.
  function automatic int default_credits(input int latency);
    return latency + 1;
  endfunction

endpackage

`endif

// File: rtl/fwft_fifo.sv
// First-word-fall-through FIFO: q shows the head whenever !empty.
// Depth need not be a power of two; pointers wrap explicitly.
module fwft_fifo #(
  parameter int width   = 32,
  parameter int depth   = 4,
  parameter int widthad = 2,
  parameter bit clken   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrreq,
  input  logic [width-1:0] data,
  input  logic             rdreq,
  output logic [width-1:0] q,
  output logic             empty,
  output logic             full
);

  logic [width-1:0]   mem [depth];
  logic [widthad-1:0] rd_ptr;
  logic [widthad-1:0] wr_ptr;
  logic [widthad:0]   count;
  logic               do_wr;
  logic               do_rd;

  localparam logic [widthad-1:0] LAST = widthad'(depth - 1);
  localparam logic [widthad:0]   FULL = (widthad + 1)'(depth);

  function automatic logic [widthad-1:0] nxt(
    input logic [widthad-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == FULL);
  assign do_wr = clken & wrreq & ~full;
  assign do_rd = clken & rdreq & ~empty;
  assign q     = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= nxt(wr_ptr);
      if (do_rd) rd_ptr <= nxt(rd_ptr);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/data_transmitter_fifo.sv
// Request FIFO + credit-gated issue to a fixed-latency FU.
// Define DATA_TRANSMITTER_BYPASS_EN for same-cycle issue when empty.
module data_transmitter_fifo
  import data_transmitter_fifo_pkg::*;
#(
  parameter int latency    = 1,
  parameter int data_width = 32,
  parameter int fifo_depth = 4,
  parameter int credit_max = default_credits(latency)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            user_valid,
  input  logic [data_width-1:0]           user_data,
  output logic                            user_ready,
  input  logic                            fu_ready,
  output logic                            op_start,
  output logic [data_width-1:0]           data_out,
  input  logic                            ret_consume,
  output logic [clog2(credit_max+1)-1:0]  credits,
  output logic                            busy
);

  localparam int CW = clog2(credit_max + 1);
  localparam int AW = clog2(fifo_depth);
  localparam logic [CW-1:0] CMAX = CW'(credit_max);

  logic [data_width-1:0] head;
  logic                  empty;
  logic                  full;
  logic                  have_credit;
  logic                  bypass;
  logic                  push;
  logic                  pop;

  assign have_credit = (credits != '0);
  assign user_ready  = reset & ~full;

`ifdef DATA_TRANSMITTER_BYPASS_EN
  assign bypass = reset & empty & user_valid
                & fu_ready & have_credit;
`else
  assign bypass = 1'b0;
`endif

  assign pop      = reset & ~empty & fu_ready & have_credit;
  assign op_start = pop | bypass;
  assign push     = user_valid & user_ready & ~bypass;

  always_comb begin
    data_out = '0;
    if (!empty)
      data_out = head;
`ifdef DATA_TRANSMITTER_BYPASS_EN
    else if (bypass)
      data_out = user_data;
`endif
  end

  fwft_fifo #(
    .width   (data_width),
    .depth   (fifo_depth),
    .widthad (AW),
    .clken   (1'b1)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wrreq (push),
    .data  (user_data),
    .rdreq (pop),
    .q     (head),
    .empty (empty),
    .full  (full)
  );

  // Saturating count; issue and return in one cycle cancel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits <= CMAX;
    end else begin
      unique case (1'b1)
        (op_start & ~ret_consume & have_credit):
          credits <= credits - 1'b1;
        (ret_consume & ~op_start & (credits != CMAX)):
          credits <= credits + 1'b1;
        default:
          credits <= credits;
      endcase
    end
  end

  assign busy = ~empty | (credits != CMAX);

`ifndef SYNTHESIS
  `DTF_NEVER(a_credit_ovf, ret_consume && credits == CMAX,
             "ret_consume with no credit outstanding")
  `DTF_NEVER(a_credit_unf, op_start && credits == '0,
             "op_start with zero credits")
`endif

endmodule

// File: tb/tb_data_transmitter_fifo.sv
// Bench for data_transmitter_fifo: directed literal checks plus a
// random run compared every cycle against a queue/counter model.
module tb_data_transmitter_fifo;

  localparam int LAT = 3;
  localparam int CM  = 4;
  localparam int DEP = 4;
  localparam int DW  = 32;

  logic          clk;
  logic          reset;
  logic          user_valid;
  logic [DW-1:0] user_data;
  logic          user_ready;
  logic          fu_ready;
  logic          op_start;
  logic [DW-1:0] data_out;
  logic          ret_consume;
  logic [2:0]    credits;
  logic          busy;

  int n_chk;
  int n_pass;

  logic [DW-1:0] mq[$];
  int            m_cr;
  logic          e_rdy;
  logic          e_byp;
  logic          e_op;
  logic [DW-1:0] e_dat;

  data_transmitter_fifo #(
    .latency    (LAT),
    .data_width (DW),
    .fifo_depth (DEP),
    .credit_max (CM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .user_valid  (user_valid),
    .user_data   (user_data),
    .user_ready  (user_ready),
    .fu_ready    (fu_ready),
    .op_start    (op_start),
    .data_out    (data_out),
    .ret_consume (ret_consume),
    .credits     (credits),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  name, act, exp);
  endtask

  // Model: a queue of pending operands and an integer credit pool.
  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      m_cr = CM;
    end else begin
      e_rdy = (mq.size() < DEP);
`ifdef DATA_TRANSMITTER_BYPASS_EN
      e_byp = (mq.size() == 0) && user_valid
           && fu_ready && (m_cr > 0);
`else
      e_byp = 1'b0;
`endif
      e_op  = fu_ready && (m_cr > 0)
           && ((mq.size() > 0) || e_byp);
      e_dat = (mq.size() > 0) ? mq[0]
            : (e_byp ? user_data : '0);
      chk("m_ready", user_ready, e_rdy);
      chk("m_op", op_start, e_op);
      chk("m_data", data_out, e_dat);
      chk("m_credits", credits, m_cr);
      chk("m_busy", busy,
          (mq.size() > 0) || (m_cr != CM));
      if (e_op && mq.size() > 0) void'(mq.pop_front());
      if (user_valid && e_rdy && !e_byp)
        mq.push_back(user_data);
      m_cr = m_cr + int'(ret_consume) - int'(e_op);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (30) begin
      cyc();
      user_valid  = 1'b0;
      fu_ready    = 1'b1;
      ret_consume = (m_cr < CM);
    end
    cyc();
    ret_consume = 1'b0;
    @(negedge clk);
    chk("drain_busy", busy, 0);
    chk("drain_credits", credits, CM);
  endtask

  int n_op;
  int v;

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b0;
    user_valid = 1'b0;
    user_data = '0;
    fu_ready = 1'b0;
    ret_consume = 1'b0;

    #12;
    chk("rst_op", op_start, 0);
    chk("rst_ready", user_ready, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_credits", credits, CM);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("rel_ready", user_ready, 1);

    // single request 0xA5
    cyc();
    user_valid = 1'b1;
    user_data = 32'hA5;
    fu_ready = 1'b1;
    @(negedge clk);
`ifdef DATA_TRANSMITTER_BYPASS_EN
    chk("a5_op0", op_start, 1);
    chk("a5_data0", data_out, 32'hA5);
`else
    chk("a5_op0", op_start, 0);
`endif
    cyc();
    user_valid = 1'b0;
    @(negedge clk);
`ifdef DATA_TRANSMITTER_BYPASS_EN
    chk("a5_op1", op_start, 0);
`else
    chk("a5_op1", op_start, 1);
    chk("a5_data1", data_out, 32'hA5);
`endif
    drain();

    // credit exhaustion: 6 requests, 4 issues
    n_op = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      user_valid = 1'b1;
      user_data = 32'h10 + i;
      fu_ready = 1'b1;
      @(negedge clk);
      n_op += int'(op_start);
    end
    cyc();
    user_valid = 1'b0;
    @(negedge clk);
    n_op += int'(op_start);
    repeat (3) begin
      cyc();
      @(negedge clk);
      n_op += int'(op_start);
    end
    chk("cr_issues", n_op, 4);
    chk("cr_zero", credits, 0);
    chk("cr_busy", busy, 1);
    chk("cr_head", data_out, 32'h14);
    cyc();
    ret_consume = 1'b1;
    @(negedge clk);
    chk("cr_hold", op_start, 0);
    cyc();
    ret_consume = 1'b0;
    @(negedge clk);
    chk("cr_ret_op", op_start, 1);
    chk("cr_ret_data", data_out, 32'h14);
    drain();

    // issue and return in the same cycle at credits=2
    cyc();
    user_valid = 1'b1;
    user_data = 32'h30;
    fu_ready = 1'b1;
    cyc();
    user_data = 32'h31;
    cyc();
    user_valid = 1'b0;
    cyc();
    cyc();
    fu_ready = 1'b0;
    user_valid = 1'b1;
    user_data = 32'h32;
    cyc();
    user_valid = 1'b0;
    fu_ready = 1'b1;
    ret_consume = 1'b1;
    @(negedge clk);
    chk("both_op", op_start, 1);
    chk("both_data", data_out, 32'h32);
    chk("both_cr_pre", credits, 2);
    cyc();
    ret_consume = 1'b0;
    fu_ready = 1'b0;
    @(negedge clk);
    chk("both_cr_post", credits, 2);
    drain();

    // fill with FU stalled, then drain in order
    v = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      fu_ready = 1'b0;
      user_valid = 1'b1;
      user_data = v;
      @(negedge clk);
      if (user_ready) v++;
    end
    chk("fill_accepts", v - 1, 4);
    chk("fill_ready", user_ready, 0);
    cyc();
    user_valid = 1'b0;
    fu_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_ready", user_ready, 0);
    chk("order_op1", op_start, 1);
    chk("order_d1", data_out, 1);
    for (int k = 2; k <= 4; k++) begin
      cyc();
      @(negedge clk);
      chk("order_op", op_start, 1);
      chk("order_d", data_out, k);
    end
    drain();

    // async reset with 3 queued and one credit left
    for (int i = 0; i < 3; i++) begin
      cyc();
      user_valid = 1'b1;
      fu_ready = 1'b1;
      user_data = 32'h40 + i;
    end
    cyc();
    user_valid = 1'b0;
    repeat (3) cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      fu_ready = 1'b0;
      user_valid = 1'b1;
      user_data = 32'h50 + i;
    end
    cyc();
    user_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_cr", credits, 1);
    chk("pre_rst_busy", busy, 1);
    cyc();
    fu_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("arst_op", op_start, 0);
    chk("arst_ready", user_ready, 0);
    chk("arst_credits", credits, CM);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_op", op_start, 0);
    chk("post_rst_cr", credits, CM);
    chk("post_rst_busy", busy, 0);

    // random traffic checked by the model every cycle
    repeat (3000) begin
      cyc();
      user_valid  = ($urandom_range(0, 2) != 0);
      user_data   = $urandom;
      fu_ready    = ($urandom_range(0, 3) != 0);
      ret_consume = (m_cr < CM) && ($urandom_range(0, 1) == 1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
